// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// program_loader: receives a length-prefixed byte image and writes it, one
// 32-bit word at a time, into instruction memory while holding the CPU in reset.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
// Revision: 1.0
// ============================================================================
module program_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [16:0] C_MAX_WORDS = 17'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         rem_q, rem_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rx_ready_q, rx_ready_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                w_accept;
  logic [15:0]         w_len;

  assign w_accept = rx_valid & rx_ready_q;
  assign w_len    = {len_hi_q, rx_data};

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    rem_d      = rem_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    // Address advances in the cycle following each write strobe.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LEN_HI;
          addr_d     = '0;
          byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      S_LEN_HI: begin
        if (w_accept) begin
          len_hi_d = rx_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_accept) begin
          byte_cnt_d = 2'd0;
          rem_d      = w_len;
          if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, w_len} > C_MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          word_d     = {word_q[15:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {word_q, rx_data};
            rem_d   = rem_q - 16'd1;
            // Final word: leave DATA now so no further byte is taken as data.
            if (rem_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          addr_d     = '0;
          byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rx_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
`ifdef LOADER_CHECKSUM_EN
                  (state_d == S_CSUM) ||
`endif
                  (state_d == S_DATA);
    cpu_reset_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_hi_q    <= 8'h00;
      rem_q       <= 16'd0;
      byte_cnt_q  <= 2'd0;
      word_q      <= 24'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      rx_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      rem_q       <= rem_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rx_ready_q  <= rx_ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
`default_nettype wire
